// File: rtl/pwm_meas_pkg.sv
// Shared types and default constants for the PWM phase-time measurement block.
package pwm_meas_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam longint unsigned DEFAULT_TIMEOUT = 64'd1 << 20;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_time_accum.sv
// Saturating phase-time accumulator: restarts from dt on an edge, otherwise adds dt.
// expired flags that the accumulated time has reached the stuck threshold.
module pwm_time_accum
  import pwm_meas_pkg::*;
#(
  parameter int              width   = DEFAULT_WIDTH,
  parameter longint unsigned timeout = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [width-1:0] dt,
  output logic [width-1:0] acc,
  output logic             expired
);

  logic [width:0]   sum;
  logic [width-1:0] sat;

  // One extra carry bit detects overflow so the sum can clamp instead of wrapping.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, dt};
    sat     = sum[width] ? '1 : sum[width-1:0];
    expired = (64'(acc) >= timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      if (load) begin
        acc <= dt;
      end else begin
        acc <= sat;
      end
    end
  end

endmodule

// File: rtl/pwm_meas.sv
// Measures high/low phase times of a PWM input in emulated time units and
// reports them after each complete high+low cycle; flags a stuck input.
module pwm_meas
  import pwm_meas_pkg::*;
#(
  parameter int              width   = DEFAULT_WIDTH,
  parameter longint unsigned timeout = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic [width-1:0] dt,
  input  logic             in,
  output logic [width-1:0] t_on,
  output logic [width-1:0] t_off,
  output logic [width:0]   period,
  output logic             valid,
  output logic             stuck
);

  state_t           state;
  logic             last;
  logic             rise;
  logic             fall;
  logic [width-1:0] acc;
  logic             expired;
  logic [width-1:0] on_hold;
  logic [width-1:0] off_hold;
  logic             pending;

  assign rise = in & ~last;
  assign fall = ~in & last;

  pwm_time_accum #(
    .width  (width),
    .timeout(timeout)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .en     (cke),
    .load   (rise | fall),
    .dt     (dt),
    .acc    (acc),
    .expired(expired)
  );

  // Results publish one clock after the closing rise, whether or not cke is high then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      last     <= 1'b1;
      on_hold  <= '0;
      off_hold <= '0;
      pending  <= 1'b0;
      t_on     <= '0;
      t_off    <= '0;
      period   <= '0;
      valid    <= 1'b0;
      stuck    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (pending) begin
        t_on    <= on_hold;
        t_off   <= off_hold;
        period  <= {1'b0, on_hold} + {1'b0, off_hold};
        valid   <= 1'b1;
        pending <= 1'b0;
      end
      if (cke) begin
        last <= in;
        // An edge always wins over the stuck threshold on the same step.
        case (state)
          SYNC: begin
            if (rise) begin
              state <= HIGH;
              stuck <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              on_hold <= acc;
              state   <= LOW;
            end else if (expired) begin
              state <= SYNC;
              stuck <= 1'b1;
            end
          end
          LOW: begin
            if (rise) begin
              off_hold <= acc;
              pending  <= 1'b1;
              state    <= HIGH;
            end else if (expired) begin
              state <= SYNC;
              stuck <= 1'b1;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_meas.sv
// Randomized and directed bench for pwm_meas: a 32-bit instance (timeout 100)
// and an 8-bit instance share stimulus and are compared to a phase-level model.
module tb_pwm_meas;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b0;
  logic        in_sig = 1'b1;
  logic [31:0] dt = '0;
  logic [7:0]  dt8 = '0;

  logic [31:0] t_on, t_off;
  logic [32:0] period;
  logic        valid, stuck;
  logic [7:0]  t_on8, t_off8;
  logic [8:0]  period8;
  logic        valid8, stuck8;

  wire [98:0] obs  = {t_on, t_off, period, valid, stuck};
  wire [26:0] obs8 = {t_on8, t_off8, period8, valid8, stuck8};

  pwm_meas #(.width(32), .timeout(64'd100)) dut (
    .clk(clk), .rst(rst), .cke(cke), .dt(dt), .in(in_sig),
    .t_on(t_on), .t_off(t_off), .period(period), .valid(valid), .stuck(stuck)
  );

  pwm_meas #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .cke(cke), .dt(dt8), .in(in_sig),
    .t_on(t_on8), .t_off(t_off8), .period(period8), .valid(valid8), .stuck(stuck8)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     r;
    bit     c;
    bit     i;
    longint d;
  } step_t;

  // Phase-level reference: while synced, the input level names the phase being timed.
  typedef struct {
    bit     prev_in;
    bit     synced;
    longint acc;
    longint on_t;
    bit     pend;
    longint p_on;
    longint p_off;
    longint t_on;
    longint t_off;
    longint period;
    bit     valid;
    bit     stuck;
  } mstate_t;

  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  mstate_t m, m8;
  step_t   seq[$];
  longint  v_on[$], v_off[$], v_per[$];
  int      v_cyc[$];

  localparam longint MAX32 = 64'hFFFF_FFFF;

  function automatic mstate_t model_reset();
    mstate_t n;
    n.prev_in = 1'b1; n.synced = 1'b0; n.acc = 0; n.on_t = 0;
    n.pend = 1'b0; n.p_on = 0; n.p_off = 0;
    n.t_on = 0; n.t_off = 0; n.period = 0; n.valid = 1'b0; n.stuck = 1'b0;
    return n;
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit r, bit c, bit i,
                                         longint d, longint maxv, longint to);
    mstate_t n;
    if (r) return model_reset();
    n = s;
    n.valid = 1'b0;
    if (s.pend) begin
      n.t_on = s.p_on; n.t_off = s.p_off; n.period = s.p_on + s.p_off;
      n.valid = 1'b1; n.pend = 1'b0;
    end
    if (!c) return n;
    if (i != s.prev_in) begin
      if (i) begin
        if (s.synced) begin
          n.pend = 1'b1; n.p_on = s.on_t; n.p_off = s.acc;
        end
        n.synced = 1'b1;
        n.stuck = 1'b0;
      end else if (s.synced) begin
        n.on_t = s.acc;
      end
      n.acc = d;
    end else begin
      if (s.synced && s.acc >= to) begin
        n.synced = 1'b0;
        n.stuck = 1'b1;
      end
      n.acc = (s.acc + d > maxv) ? maxv : s.acc + d;
    end
    n.prev_in = i;
    return n;
  endfunction

  function automatic logic [98:0] vec32(mstate_t s);
    return {32'(s.t_on), 32'(s.t_off), 33'(s.period), s.valid, s.stuck};
  endfunction

  function automatic logic [26:0] vec8(mstate_t s);
    return {8'(s.t_on), 8'(s.t_off), 9'(s.period), s.valid, s.stuck};
  endfunction

  task automatic add(input bit lvl, input int n, input longint d);
    step_t s;
    s.r = 1'b0; s.c = 1'b1; s.i = lvl; s.d = d;
    repeat (n) seq.push_back(s);
  endtask

  task automatic add_rst(input bit lvl, input int n);
    step_t s;
    s.r = 1'b1; s.c = 1'b1; s.i = lvl; s.d = 1;
    repeat (n) seq.push_back(s);
  endtask

  task automatic clear_records();
    v_on.delete(); v_off.delete(); v_per.delete(); v_cyc.delete();
  endtask

  // Applies one clock of stimulus, advances both models and logs valid pulses.
  task automatic drive(input step_t s);
    @(negedge clk);
    rst = s.r; cke = s.c; in_sig = s.i; dt = 32'(s.d); dt8 = 8'(s.d);
    @(posedge clk);
    #1;
    cyc++;
    m  = model_next(m,  s.r, s.c, s.i, s.d, MAX32, 100);
    m8 = model_next(m8, s.r, s.c, s.i, s.d & 255, 255, 64'd1 << 20);
    if (valid) begin
      v_on.push_back(t_on); v_off.push_back(t_off); v_per.push_back(period); v_cyc.push_back(cyc);
    end
  endtask

  task automatic test_reset();
    add_rst(1'b1, 3);
    foreach (seq[k]) drive(seq[k]);
    seq.delete();
    total++;
    if (obs !== 99'd0) begin bad++; $display("[TB] FAIL reset32 got=%h want=0", obs); end
    total++;
    if (obs8 !== 27'd0) begin bad++; $display("[TB] FAIL reset8 got=%h want=0", obs8); end
  endtask

  task automatic test_basic();
    clear_records();
    add_rst(1'b1, 2);
    add(1'b0, 2, 1);
    repeat (4) begin add(1'b1, 3, 1); add(1'b0, 5, 1); end
    add(1'b1, 2, 1);
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL basic_model cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
    end
    seq.delete();
    total++;
    if (v_on.size() != 4) begin bad++; $display("[TB] FAIL basic_count got=%0d want=4", v_on.size()); end
    for (int k = 0; k < v_on.size(); k++) begin
      total++;
      if (v_on[k] != 3 || v_off[k] != 5 || v_per[k] != 8)
        begin bad++; $display("[TB] FAIL basic_values got=%0d/%0d/%0d want=3/5/8", v_on[k], v_off[k], v_per[k]); end
      if (k > 0) begin
        total++;
        if (v_cyc[k] - v_cyc[k-1] != 8)
          begin bad++; $display("[TB] FAIL basic_spacing got=%0d want=8", v_cyc[k] - v_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_cke_gating();
    bit lvls[$];
    step_t s;
    clear_records();
    add_rst(1'b1, 2);
    lvls = '{0, 0};
    repeat (4) lvls = {lvls, 1'b1, 1'b1, 1'b0, 1'b0};
    lvls = {lvls, 1'b1, 1'b1};
    foreach (lvls[j]) begin
      add(lvls[j], 1, 10);
      s.r = 1'b0; s.c = 1'b0; s.i = 1'($urandom_range(0, 1)); s.d = $urandom_range(0, 1000);
      seq.push_back(s);
    end
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL cke_model cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
    end
    seq.delete();
    total++;
    if (v_on.size() != 4) begin bad++; $display("[TB] FAIL cke_count got=%0d want=4", v_on.size()); end
    for (int k = 0; k < v_on.size(); k++) begin
      total++;
      if (v_on[k] != 20 || v_off[k] != 20 || v_per[k] != 40)
        begin bad++; $display("[TB] FAIL cke_values got=%0d/%0d/%0d want=20/20/40", v_on[k], v_off[k], v_per[k]); end
    end
  endtask

  task automatic test_sync_start();
    clear_records();
    add_rst(1'b1, 2);
    add(1'b1, 10, 1); add(1'b0, 4, 1); add(1'b1, 6, 1); add(1'b0, 4, 1); add(1'b1, 2, 1);
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL sync_model cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
    end
    seq.delete();
    total++;
    if (v_on.size() != 1) begin bad++; $display("[TB] FAIL sync_count got=%0d want=1", v_on.size()); end
    else begin
      total++;
      if (v_on[0] != 6 || v_off[0] != 4 || v_per[0] != 10 || v_cyc[0] != cyc)
        begin bad++; $display("[TB] FAIL sync_values got=%0d/%0d/%0d@%0d want=6/4/10@%0d", v_on[0], v_off[0], v_per[0], v_cyc[0], cyc); end
    end
  endtask

  task automatic test_timeout();
    clear_records();
    add_rst(1'b1, 2);
    add(1'b0, 2, 1); add(1'b1, 3, 1); add(1'b0, 5, 1); add(1'b1, 3, 1);
    foreach (seq[k]) drive(seq[k]);
    seq.delete();
    add(1'b0, 105, 1);
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL timeout_model cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
      if (k < 99 && stuck !== 1'b0) begin
        total++; bad++; $display("[TB] FAIL timeout_early step=%0d got=%b want=0", k, stuck);
      end
    end
    seq.delete();
    total++;
    if (stuck !== 1'b1 || t_on !== 32'd3 || t_off !== 32'd5 || period !== 33'd8)
      begin bad++; $display("[TB] FAIL timeout_hold got=%b %0d/%0d/%0d want=1 3/5/8", stuck, t_on, t_off, period); end
    total++;
    if (v_on.size() != 1) begin bad++; $display("[TB] FAIL timeout_novalid got=%0d want=1", v_on.size()); end
    add(1'b1, 3, 1); add(1'b0, 4, 1); add(1'b1, 2, 1);
    foreach (seq[k]) begin
      drive(seq[k]);
      if (k == 0) begin
        total++;
        if (stuck !== 1'b0) begin bad++; $display("[TB] FAIL timeout_clear got=%b want=0", stuck); end
      end
    end
    seq.delete();
    total++;
    if (v_on.size() != 2) begin bad++; $display("[TB] FAIL timeout_recover_count got=%0d want=2", v_on.size()); end
    else begin
      total++;
      if (v_on[1] != 3 || v_off[1] != 4 || v_per[1] != 7)
        begin bad++; $display("[TB] FAIL timeout_recover got=%0d/%0d/%0d want=3/4/7", v_on[1], v_off[1], v_per[1]); end
    end
  endtask

  task automatic test_saturation();
    int n8 = 0;
    add_rst(1'b1, 2);
    add(1'b0, 1, 200); add(1'b1, 3, 200); add(1'b0, 1, 200); add(1'b1, 2, 200);
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs8 !== vec8(m8)) begin bad++; $display("[TB] FAIL sat_model8 cyc=%0d got=%h want=%h", cyc, obs8, vec8(m8)); end
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL sat_model32 cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
      if (valid8) begin
        n8++;
        total++;
        if (t_on8 !== 8'd255 || t_off8 !== 8'd200 || period8 !== 9'd455)
          begin bad++; $display("[TB] FAIL sat_values got=%0d/%0d/%0d want=255/200/455", t_on8, t_off8, period8); end
      end
    end
    seq.delete();
    total++;
    if (n8 != 1) begin bad++; $display("[TB] FAIL sat_count got=%0d want=1", n8); end
  endtask

  task automatic test_reset_mid_low();
    clear_records();
    add_rst(1'b1, 2);
    add(1'b0, 2, 1); add(1'b1, 3, 1); add(1'b0, 5, 1); add(1'b1, 3, 1); add(1'b0, 2, 1);
    add_rst(1'b0, 1);
    foreach (seq[k]) drive(seq[k]);
    seq.delete();
    total++;
    if (obs !== 99'd0) begin bad++; $display("[TB] FAIL midrst_clear got=%h want=0", obs); end
    total++;
    if (v_on.size() != 1) begin bad++; $display("[TB] FAIL midrst_pre_count got=%0d want=1", v_on.size()); end
    add(1'b0, 3, 1); add(1'b1, 2, 1); add(1'b0, 2, 1); add(1'b1, 2, 1);
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL midrst_model cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
    end
    seq.delete();
    total++;
    if (v_on.size() != 2) begin bad++; $display("[TB] FAIL midrst_count got=%0d want=2", v_on.size()); end
    else begin
      total++;
      if (v_on[1] != 2 || v_off[1] != 2 || v_per[1] != 4)
        begin bad++; $display("[TB] FAIL midrst_values got=%0d/%0d/%0d want=2/2/4", v_on[1], v_off[1], v_per[1]); end
    end
  endtask

  task automatic test_random();
    step_t s;
    bit lvl = 1'b1;
    add_rst(1'b1, 2);
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      s.r = ($urandom_range(0, 199) == 0);
      s.c = ($urandom_range(0, 9) < 7);
      s.i = lvl;
      s.d = $urandom_range(0, 30);
      seq.push_back(s);
    end
    foreach (seq[k]) begin
      drive(seq[k]);
      total++;
      if (obs !== vec32(m)) begin bad++; $display("[TB] FAIL rand_model32 cyc=%0d got=%h want=%h", cyc, obs, vec32(m)); end
      total++;
      if (obs8 !== vec8(m8)) begin bad++; $display("[TB] FAIL rand_model8 cyc=%0d got=%h want=%h", cyc, obs8, vec8(m8)); end
    end
    seq.delete();
  endtask

  initial begin
    m  = model_reset();
    m8 = model_reset();
    test_reset();
    test_basic();
    test_cke_gating();
    test_sync_start();
    test_timeout();
    test_saturation();
    test_reset_mid_low();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
